// File: rtl/pointwise_input_streamer.sv
// pointwise_input_streamer
//   Feeds the pointwise accelerator's input stream. Host pixels are buffered
//   in a small show-ahead FIFO. The head word is held in a register that
//   drives the accelerator read-data port. The block primes before
//   streaming, counts one frame, pulses frame_done, and flags reads that
//   arrive with no data available.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear; same state as reset, wins over push/pop
//   in_valid       host word valid
//   in_data        host word
//   in_ready       streamer accepts a host word
//   hw_..._read_en pop request from the accelerator
//   hw_..._read    registered head word (show-ahead)
//   stream_ready   high exactly while streaming
//   frame_done     one-cycle pulse after the last frame word is popped
//   level          words held, head included
//   underflow      sticky: read request with nothing poppable
//
// state  | meaning
// -------+------------------------------------------------------------
// FILL   | priming; reads are refused and flagged as underflow
// STREAM | accelerator pops the head word on read_en
// DONE   | whole frame popped; input closed, reads ignored until flush
module pointwise_input_streamer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int PRIME       = 4,
  parameter int FRAME_WORDS = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
  output logic [WIDTH-1:0]         hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read,
  output logic                     stream_ready,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_WORDS) + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME);
  localparam logic [CW-1:0] FRAME_L = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] LAST_L  = CW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    level_q, level_d;
  logic [CW-1:0]    pushed_q, pushed_d;
  logic [CW-1:0]    popped_q, popped_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             in_ready_q, in_ready_d;
  logic             underflow_q, underflow_d;
  logic             frame_done_q, frame_done_d;

  logic             read_en;
  logic             push;
  logic             pop;
  logic             uf_event;

  assign read_en = hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en;

  always_comb begin
    push     = in_valid && in_ready_q;
    pop      = read_en && (state_q == S_STREAM) && (level_q != '0);
    uf_event = read_en && ((state_q == S_FILL) ||
                           ((state_q == S_STREAM) && (level_q == '0)));

    rd_ptr_nxt   = rd_ptr_q + AW'(1);
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_nxt        : rd_ptr_q;
    state_d      = state_q;
    level_d      = level_q;
    pushed_d     = pushed_q;
    popped_d     = popped_q;
    head_d       = head_q;
    underflow_d  = underflow_q || uf_event;
    frame_done_d = 1'b0;

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (push && (pushed_q != FRAME_L)) pushed_d = pushed_q + CW'(1);
    if (pop  && (popped_q != FRAME_L)) popped_d = popped_q + CW'(1);

    // Head register tracks the word that will be at the read pointer after
    // the edge. The incoming word is taken directly when the buffer is
    // (or is about to become) empty, because its memory slot is only
    // written at this same edge.
    if (pop && (level_q > LW'(1))) begin
      head_d = mem[rd_ptr_nxt];
    end else if (push && ((level_q == '0) || (pop && (level_q == LW'(1))))) begin
      head_d = in_data;
    end

    case (state_q)
      S_FILL: begin
        if ((level_q >= PRIME_L) || (pushed_q == FRAME_L)) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (pop && (popped_q == LAST_L)) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_FILL;
    endcase

    // Registered ready, computed from next-cycle state; no pop-to-push
    // bypass when full.
    in_ready_d = (level_d < DEPTH_L) && (pushed_d < FRAME_L) && (state_d != S_DONE);

    if (flush) begin
      state_d      = S_FILL;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      pushed_d     = '0;
      popped_d     = '0;
      head_d       = '0;
      underflow_d  = 1'b0;
      frame_done_d = 1'b0;
      in_ready_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pushed_q     <= '0;
      popped_q     <= '0;
      head_q       <= '0;
      in_ready_q   <= 1'b0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pushed_q     <= pushed_d;
      popped_q     <= popped_d;
      head_q       <= head_d;
      in_ready_q   <= in_ready_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage carries no reset; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= in_data;
  end

  assign in_ready     = in_ready_q;
  assign stream_ready = (state_q == S_STREAM);
  assign frame_done   = frame_done_q;
  assign level        = level_q;
  assign underflow    = underflow_q;
  assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read = head_q;

endmodule

// File: tb/tb_pointwise_input_streamer.sv
module tb_pointwise_input_streamer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int PRIME = 4;
  localparam int FW    = 16;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             read_en;
  logic [WIDTH-1:0] rd_data;
  logic             stream_ready;
  logic             frame_done;
  logic [3:0]       level;
  logic             underflow;

  int total = 0;
  int bad   = 0;

  pointwise_input_streamer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PRIME(PRIME), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en(read_en),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read(rd_data),
    .stream_ready(stream_ready),
    .frame_done(frame_done),
    .level(level),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        re;
    logic [15:0] e_rd;
    logic [3:0]  e_lvl;
    logic        e_ir;
    logic        e_sr;
    logic        e_uf;
    logic        e_fd;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic fl, input logic iv, input logic [15:0] d,
                              input logic re, input logic [15:0] e_rd,
                              input logic [3:0] e_lvl, input logic e_ir,
                              input logic e_sr, input logic e_uf, input logic e_fd);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.re = re;
    v.e_rd = e_rd; v.e_lvl = e_lvl; v.e_ir = e_ir;
    v.e_sr = e_sr; v.e_uf = e_uf; v.e_fd = e_fd;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] e_rd, input logic [3:0] e_lvl,
                         input logic e_ir, input logic e_sr, input logic e_uf, input logic e_fd);
    chk({nm, ".read"},         32'(rd_data),      32'(e_rd));
    chk({nm, ".level"},        32'(level),        32'(e_lvl));
    chk({nm, ".in_ready"},     32'(in_ready),     32'(e_ir));
    chk({nm, ".stream_ready"}, 32'(stream_ready), 32'(e_sr));
    chk({nm, ".underflow"},    32'(underflow),    32'(e_uf));
    chk({nm, ".frame_done"},   32'(frame_done),   32'(e_fd));
  endtask

  task automatic step(input logic fl, input logic iv, input logic [15:0] d, input logic re);
    flush = fl; in_valid = iv; in_data = d; read_en = re;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; read_en = 1'b0;

    // Frame stream: prime with 0..3, then pop every cycle while pushing 4..15.
    for (int i = 0; i < 4; i++) add(0, 1, 16'(i), 0, 16'h0, 4'(i + 1), 1, 0, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0, 4'd4, 1, 1, 0, 0);
    for (int j = 0; j < 12; j++)
      add(0, 1, 16'(4 + j), 1, 16'(j + 1), 4'd4, (j == 11) ? 1'b0 : 1'b1, 1, 0, 0);
    for (int k = 0; k < 4; k++)
      add(0, 0, 16'h0, 1, (k < 3) ? 16'(13 + k) : 16'd15, 4'(3 - k), 0,
          (k == 3) ? 1'b0 : 1'b1, 0, (k == 3) ? 1'b1 : 1'b0);
    // DONE: input closed, read ignored, head holds last word.
    add(0, 1, 16'h0055, 1, 16'd15, 4'd0, 0, 0, 0, 0);
    add(1, 0, 16'h0, 0, 16'h0, 4'd0, 1, 0, 0, 0);
    // Underflow while still priming.
    add(0, 1, 16'h00A1, 0, 16'h00A1, 4'd1, 1, 0, 0, 0);
    add(0, 1, 16'h00A2, 0, 16'h00A1, 4'd2, 1, 0, 0, 0);
    add(0, 0, 16'h0, 1, 16'h00A1, 4'd2, 1, 0, 1, 0);
    add(1, 0, 16'h0, 0, 16'h0, 4'd0, 1, 0, 0, 0);

    #2;
    chk_all("reset", 16'h0, 4'd0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("reset_edge.in_ready", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].fl, vq[i].iv, vq[i].d, vq[i].re);
      chk_all($sformatf("vec%0d", i), vq[i].e_rd, vq[i].e_lvl, vq[i].e_ir,
              vq[i].e_sr, vq[i].e_uf, vq[i].e_fd);
    end

    // Full buffer: no pop-to-push bypass.
    for (int i = 0; i < 8; i++) step(0, 1, 16'(16'h20 + i), 0);
    chk_all("full", 16'h0020, 4'd8, 0, 1, 0, 0);
    step(0, 1, 16'h0099, 1);
    chk_all("full_pop", 16'h0021, 4'd7, 1, 1, 0, 0);
    step(0, 0, 16'h0, 0);
    chk_all("full_after", 16'h0021, 4'd7, 1, 1, 0, 0);
    step(1, 0, 16'h0, 0);

    // Drain to empty, push with read on empty, then hold after underflow.
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h30 + i), 0);
    step(0, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1);
    chk_all("drained", 16'h0033, 4'd0, 1, 1, 0, 0);
    step(0, 1, 16'hBEEF, 1);
    chk_all("beef", 16'hBEEF, 4'd1, 1, 1, 1, 0);
    step(0, 0, 16'h0, 1);
    chk_all("beef_pop", 16'hBEEF, 4'd0, 1, 1, 1, 0);
    step(0, 0, 16'h0, 1);
    chk_all("empty_read", 16'hBEEF, 4'd0, 1, 1, 1, 0);
    step(1, 0, 16'h0, 0);

    // Flush mid-frame after five pops, then a fresh frame from word 0.
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h40 + i), 0);
    step(0, 0, 16'h0, 0);
    chk_all("mid_primed", 16'h0040, 4'd4, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 16'(16'h44 + i), 1);
      chk($sformatf("mid_pop%0d.read", i), 32'(rd_data), 32'(16'h41 + i));
    end
    step(1, 0, 16'h0, 0);
    chk_all("mid_flush", 16'h0, 4'd0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h50 + i), 0);
    step(0, 0, 16'h0, 0);
    chk_all("new_frame", 16'h0050, 4'd4, 1, 1, 0, 0);
    step(0, 0, 16'h0, 1);
    chk_all("new_pop0", 16'h0051, 4'd3, 1, 1, 0, 0);
    step(0, 0, 16'h0, 1);
    chk_all("new_pop1", 16'h0052, 4'd2, 1, 1, 0, 0);

    // Asynchronous reset mid-cycle while streaming.
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0, 4'd0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("async_rst_edge.in_ready", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("async_release.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h60 + i), 0);
    step(0, 0, 16'h0, 0);
    chk_all("refill", 16'h0060, 4'd4, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pointwise_input_streamer.md
Name: pointwise_input_streamer

Overview:
Upstream feeder for the pointwise accelerator's input stream port. It buffers host-supplied pixels in a small show-ahead FIFO and presents the head word on the pointwise read-data port. It advances to the next word each cycle the accelerator asserts read_en. It primes before streaming, counts one frame, signals completion, and flags reads that arrive when no data is available.

Parameters:
WIDTH, 16, pixel width in bits
DEPTH, 8, FIFO capacity in words including the head register; power of 2, >= 2
PRIME, 4, words required before streaming starts; 1..DEPTH
FRAME_WORDS, 4096, words per frame (64x64)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear, same meaning as the accelerator's flush
in_valid  in  1  host word valid
in_data  in  WIDTH  host word
in_ready  out  1  streamer accepts a host word
hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en  in  1  pop request from the accelerator
hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read  out  WIDTH  head word; drives element [0] of the accelerator's one-lane array port
stream_ready  out  1  primed; the accelerator may be released from flush
frame_done  out  1  one-cycle pulse after the last frame word is popped
level  out  $clog2(DEPTH)+1  words held
underflow  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0, async) and flush=1 at a rising edge apply the same state: FSM=FILL, level=0, pointers=0, push and pop counters=0, read output=0, in_ready=0 during reset, stream_ready=0, frame_done=0, underflow=0.
- flush has priority over push and pop in the same cycle. in_ready=1 in the cycle after reset or flush is released.
- Push occurs when in_valid && in_ready. in_ready = (level<DEPTH) && (pushed<FRAME_WORDS) && FSM!=DONE.
- There is no pop-to-push bypass at full: in_ready is low when level==DEPTH, even if a pop happens in the same cycle.
- The read output is a registered head word, so it is show-ahead.
- Push into an empty buffer: the word appears on the read output at the next edge. Latency is 1.
- Pop: read_en is sampled at the rising edge while FSM=STREAM and level>0. The consumer uses the current head word in that cycle. The next word appears after the edge.
- After the last word is popped, the read output holds its final value. It is never cleared except by reset or flush.
- Simultaneous push and pop: level is unchanged and FIFO order is preserved.
- Push and pop with level==1: the pushed word becomes the head after the edge.
- Underflow is set, with no pop, when read_en=1 and either FSM=FILL or level==0.
- Underflow with a push in the same cycle: the push still occurs; there is no bypass to the output.
- underflow stays set until reset or flush.
- FSM:
  - FILL -> STREAM when level>=PRIME, or when pushed==FRAME_WORDS (short tail).
  - STREAM -> DONE on the pop that makes popped==FRAME_WORDS. frame_done pulses for exactly one cycle after that edge.
  - DONE: in_ready=0, read_en is ignored (no underflow), stream_ready=0. DONE is left only by flush or reset.
- stream_ready=1 exactly while FSM=STREAM. It stays high in STREAM even if level later drops below PRIME.
- Counters are $clog2(FRAME_WORDS)+1 bits wide and saturate at FRAME_WORDS.
- Memory is read combinationally into the head register. No multicycle paths.

Test Plan:
- DEPTH=8, PRIME=4, FRAME_WORDS=16: push 0..3 -> stream_ready rises on the edge after the 4th push, read=0. Pop every cycle while pushing 4..15 -> the accelerator receives 0..15 in order, frame_done pulses once, FSM=DONE, in_ready=0.
- Fill to level=8 -> in_ready=0. Assert in_valid with read_en in the same cycle -> pop only, level=7; in_ready=1 next cycle.
- FILL with level=2, read_en=1 -> underflow=1, level unchanged, read=first word. In STREAM, drain to empty, then read_en=1 -> underflow=1, read holds the last value.
- Empty buffer with push of 0xBEEF and read_en in the same cycle (STREAM) -> underflow=1, level=1, read=0xBEEF after the edge.
- Mid-frame (popped=5) assert flush for 1 cycle -> level=0, read=0, underflow=0, FSM=FILL. A new frame streams from word 0 correctly.
- rst_n low asynchronously mid-cycle during STREAM -> all outputs go to reset values immediately, with no clock edge required. Release, then refill 4 words -> stream_ready=1.
